// File: rtl/sar_search_4b.sv
// Successive-approximation search controller driving a G/L/E magnitude comparator.
// Binary-searches the comparator's unknown 'a' input by presenting trial values on 'probe'.
module sar_search_4b #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic [N-1:0]  probe,
    input  logic          G,
    input  logic          L,
    input  logic          E,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result,
    output logic [SW-1:0] steps,
    output logic          err
);

    localparam int unsigned KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  probe_q, probe_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;
    logic [N-1:0]  result_q, result_d;
    logic [SW-1:0] steps_q, steps_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [N-1:0]  acc_upd;
    logic          flags_ok;

    // Exactly one of G/L/E must be asserted for a trial to be trusted
    assign flags_ok = (G & ~L & ~E) | (~G & L & ~E) | (~G & ~L & E);

    // State and registered-output update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            probe_q  <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
            steps_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic; busy/done track the state being entered
    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        acc_d    = acc_q;
        k_d      = k_q;
        result_d = result_q;
        steps_d  = steps_q;
        err_d    = err_q;
        acc_upd  = acc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TRIAL;
                    probe_d = {1'b1, {(N-1){1'b0}}};
                    k_d     = KW'(N - 1);
                    acc_d   = '0;
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            TRIAL: begin
                steps_d = steps_q + SW'(1);
                if (!flags_ok) begin
                    err_d    = 1'b1;
                    result_d = acc_q;
                    state_d  = FIN;
                end else if (E) begin
                    result_d = probe_q;
                    state_d  = FIN;
                end else if (k_q == '0) begin
                    // L here proves a == acc; G contradicts earlier answers
                    result_d = acc_q;
                    err_d    = G;
                    state_d  = FIN;
                end else begin
                    acc_upd = G ? (acc_q | (N'(1) << k_q)) : acc_q;
                    acc_d   = acc_upd;
                    k_d     = k_q - KW'(1);
                    probe_d = acc_upd | (N'(1) << (k_q - KW'(1)));
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered status flags derived from the upcoming state
    always_comb begin
        busy_d = (state_d == TRIAL);
        done_d = (state_d == FIN);
    end

    assign probe  = probe_q;
    assign result = result_q;
    assign steps  = steps_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
